// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, MEM-stage hold on a
// busy data memory, and branch flush with a deferred-branch latch for branches
// that resolve while memory is holding. Control outputs are combinational
// (same-cycle effect); only the FSM state, br_pend and StallCount are stored.
module hazard_stall_ctrl #(
  parameter int unsigned XZR_IDX = 31,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rn,
  input  logic [4:0]       ID_Rm,
  input  logic             ID_UsesRm,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rd,
  input  logic             BranchTaken,
  input  logic             MemBusy,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IDEX_Stall,
  output logic             EXMEM_Stall,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

  localparam logic [4:0] XZR = 5'(XZR_IDX);

  state_t           state_q, state_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, branch;
  logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic             idex_bubble, flush_all;

  // The zero register never carries a real dependency.
  assign load_use = EX_MemRead && (EX_Rd != XZR) &&
                    ((EX_Rd == ID_Rn) || (ID_UsesRm && (EX_Rd == ID_Rm)));
  assign branch   = BranchTaken || br_pend_q;

  // Priority decode: memory hold > branch flush > load-use interlock.
  always_comb begin
    state_d     = RUN;
    br_pend_d   = br_pend_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    idex_bubble = 1'b0;
    flush_all   = 1'b0;
    if (MemBusy) begin
      // Whole front of the pipe holds; a branch arriving now is deferred.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      br_pend_d   = br_pend_q | BranchTaken;
      state_d     = MEMWAIT;
    end else if (state_q == FLUSH) begin
      // ID holds a flushed NOP, so any apparent load-use is stale.
      state_d = RUN;
    end else if (branch) begin
      flush_all = 1'b1;
      br_pend_d = 1'b0;
      state_d   = FLUSH;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign PC_Stall    = Reset & pc_stall;
  assign IFID_Stall  = Reset & ifid_stall;
  assign IDEX_Stall  = Reset & idex_stall;
  assign EXMEM_Stall = Reset & exmem_stall;
  assign IDEX_Bubble = Reset & idex_bubble;
  assign IFID_Flush  = Reset & flush_all;
  assign IDEX_Flush  = Reset & flush_all;
  assign EXMEM_Flush = Reset & flush_all;

  // Saturating count of PC-stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (PC_Stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  assign StallCount = cnt_q;

  // State, deferred-branch flag and counter; reset drops any pending branch.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a second instance with CNT_W=4 shares
// the stimulus to exercise counter saturation.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rn, ID_Rm, EX_Rd;
  logic        ID_UsesRm, EX_MemRead, BranchTaken, MemBusy;
  logic        PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall, IDEX_Bubble;
  logic        IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic [15:0] StallCount;
  logic        s4_pc, s4_ifid, s4_idex, s4_exmem, s4_bub, s4_f1, s4_f2, s4_f3;
  logic [3:0]  StallCount4;

  int checks = 0;
  int errors = 0;

  // {PC,IFID,IDEX,EXMEM stall, bubble, IFID,IDEX,EXMEM flush}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] ST4  = 8'b1111_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] FL   = 8'b0000_0111;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .Reset(Reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UsesRm(ID_UsesRm),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PC_Stall(PC_Stall), .IFID_Stall(IFID_Stall), .IDEX_Stall(IDEX_Stall),
    .EXMEM_Stall(EXMEM_Stall), .IDEX_Bubble(IDEX_Bubble), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .StallCount(StallCount)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .Reset(Reset), .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UsesRm(ID_UsesRm),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PC_Stall(s4_pc), .IFID_Stall(s4_ifid), .IDEX_Stall(s4_idex),
    .EXMEM_Stall(s4_exmem), .IDEX_Bubble(s4_bub), .IFID_Flush(s4_f1),
    .IDEX_Flush(s4_f2), .EXMEM_Flush(s4_f3), .StallCount(StallCount4)
  );

  wire [7:0] outs = {PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall,
                     IDEX_Bubble, IFID_Flush, IDEX_Flush, EXMEM_Flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output vector check; also enforces that stall and flush never coincide.
  task automatic chk_out(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, outs}, {24'd0, exp});
    chk({tag, "_nostallflush"}, {31'd0, (|outs[7:4]) & (|outs[2:0])}, 32'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rn, input logic [4:0] rm, input logic uses,
                        input logic mr, input logic [4:0] rd);
    ID_Rn = rn; ID_Rm = rm; ID_UsesRm = uses; EX_MemRead = mr; EX_Rd = rd;
  endtask

  initial begin
    Reset = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
    set_lu(5'd3, 5'd0, 1'b0, 1'b1, 5'd3);   // load-use present during reset
    tick;
    chk_out("reset_outs", NONE);
    chk("reset_cnt", {16'd0, StallCount}, 32'd0);
    MemBusy = 1'b1;
    chk_out("reset_membusy_outs", NONE);
    MemBusy = 1'b0;

    // Basic load-use interlock
    Reset = 1'b1;
    chk_out("lu_rn", LU);
    tick;
    chk("lu_cnt1", {16'd0, StallCount}, 32'd1);
    set_lu(5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    chk_out("lu_cleared", NONE);

    // Zero register and unused Rm never interlock
    set_lu(5'd31, 5'd0, 1'b0, 1'b1, 5'd31);
    chk_out("xzr_nostall", NONE);
    set_lu(5'd0, 5'd5, 1'b0, 1'b1, 5'd5);
    chk_out("rm_unused", NONE);
    ID_UsesRm = 1'b1;
    chk_out("rm_used", LU);
    EX_MemRead = 1'b0;
    chk_out("not_load", NONE);
    EX_MemRead = 1'b1;
    tick;
    chk("lu_cnt2", {16'd0, StallCount}, 32'd2);
    set_lu(5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

    // MemBusy 3 cycles with deferred branch
    MemBusy = 1'b1;
    chk_out("mb_c1", ST4);
    tick;
    BranchTaken = 1'b1;
    chk_out("mb_c2", ST4);
    tick;
    BranchTaken = 1'b0;
    chk_out("mb_c3", ST4);
    tick;
    MemBusy = 1'b0;
    chk_out("mb_deferred_flush", FL);
    chk("mb_cnt", {16'd0, StallCount}, 32'd5);
    tick;
    chk_out("mb_flush_state", NONE);
    tick;
    chk_out("mb_back_run", NONE);

    // Branch beats load-use; load-use ignored in FLUSH
    set_lu(5'd7, 5'd0, 1'b0, 1'b1, 5'd7);
    BranchTaken = 1'b1;
    chk_out("br_over_lu", FL);
    tick;
    BranchTaken = 1'b0;
    chk_out("flush_ignores_lu", NONE);
    tick;
    chk_out("lu_after_flush", LU);
    tick;
    chk("br_lu_cnt", {16'd0, StallCount}, 32'd6);
    set_lu(5'd0, 5'd0, 1'b0, 1'b0, 5'd0);

    // Long MemBusy: narrow counter saturates
    MemBusy = 1'b1;
    for (int i = 0; i < 20; i++) tick;
    chk("sat_cnt4", {28'd0, StallCount4}, 32'd15);
    chk("wide_cnt", {16'd0, StallCount}, 32'd26);
    MemBusy = 1'b0;
    chk_out("mb_release_nobr", NONE);
    tick;
    chk("sat_hold", {28'd0, StallCount4}, 32'd15);

    // Async reset mid-MEMWAIT with a pending branch
    MemBusy = 1'b1;
    tick;
    BranchTaken = 1'b1;
    tick;
    BranchTaken = 1'b0;
    #1;
    Reset = 1'b0;
    chk_out("async_rst_outs", NONE);
    chk("async_rst_cnt", {16'd0, StallCount}, 32'd0);
    chk("async_rst_cnt4", {28'd0, StallCount4}, 32'd0);
    MemBusy = 1'b0;
    tick;
    Reset = 1'b1;
    chk_out("post_rst_noflush", NONE);
    tick;
    chk_out("post_rst_edge_noflush", NONE);
    set_lu(5'd9, 5'd0, 1'b0, 1'b1, 5'd9);
    chk_out("post_rst_lu", LU);
    tick;
    chk("post_rst_cnt", {16'd0, StallCount}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
